// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage.
package mem_pkg;

  localparam int XLEN = 64;

  // Load type encodings
  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LD  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;
  localparam logic [2:0] LT_LWU = 3'b110;

  // Store type encodings
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;
  localparam logic [1:0] ST_SD = 2'b11;

  typedef enum logic {IDLE, BUSY} state_t;

  // Access size in bytes (1/2/4/8). The low two bits of the load type give
  // log2(size) for every encoding, including the unsigned ones and 111 (ld).
  function automatic logic [3:0] access_size(input logic       is_store,
                                             input logic [2:0] load_type,
                                             input logic [1:0] store_type);
    logic [1:0] log_size;
    log_size = is_store ? store_type : load_type[1:0];
    return 4'd1 << log_size;
  endfunction

  // Contiguous byte mask of the given size, starting at lane 0.
  function automatic logic [7:0] size_mask(input logic [3:0] size);
    logic [8:0] mask;
    mask = (9'd1 << size) - 9'd1;
    return mask[7:0];
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment: store lane placement, load extraction/extension and
// misalignment detection for a single 64-bit doubleword.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]      offset,
  input  logic            is_store,
  input  logic [2:0]      load_type,
  input  logic [1:0]      store_type,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_raw,
  output logic [7:0]      byte_en,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  logic [3:0]      size;
  logic [XLEN-1:0] lane;

  // Lane placement for stores and lane extraction/extension for loads
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    load_data  = '0;
    size       = access_size(is_store, load_type, store_type);
    misaligned = ({1'b0, offset} + size) > 4'd8;
    byte_en    = is_store ? (size_mask(size) << offset) : 8'hFF;
    wdata      = store_data << {offset, 3'b000};
    lane       = load_raw >> {offset, 3'b000};
    case (load_type)
      LT_LB:   load_data = {{56{lane[7]}},  lane[7:0]};
      LT_LH:   load_data = {{48{lane[15]}}, lane[15:0]};
      LT_LW:   load_data = {{32{lane[31]}}, lane[31:0]};
      LT_LBU:  load_data = {56'd0, lane[7:0]};
      LT_LHU:  load_data = {48'd0, lane[15:0]};
      LT_LWU:  load_data = {32'd0, lane[31:0]};
      default: load_data = lane;  // ld and the unused 111 encoding
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: turns loads/stores into a req/ack cache
// transaction, extends load data and forwards a writeback packet.
module mem_access
  import mem_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      inValid,
  input  logic [BUS_DATA_WIDTH-1:0] inResult,
  input  logic [BUS_DATA_WIDTH-1:0] inDataReg2,
  input  logic                      inMemRead,
  input  logic                      inMemWrite,
  input  logic                      inMemOrReg,
  input  logic                      inRegWrite,
  input  logic [4:0]                inDestRegister,
  input  logic [2:0]                inLoadType,
  input  logic [1:0]                inStoreType,
  output logic                      outMemReq,
  output logic                      outMemWe,
  output logic [ADDR_WIDTH-1:0]     outMemAddr,
  output logic [BUS_DATA_WIDTH-1:0] outMemWdata,
  output logic [7:0]                outMemByteEn,
  input  logic                      inMemAck,
  input  logic [BUS_DATA_WIDTH-1:0] inMemRdata,
  output logic                      outStall,
  output logic                      outValid,
  output logic                      outRegWrite,
  output logic [4:0]                outDestRegister,
  output logic [BUS_DATA_WIDTH-1:0] outWriteData,
  output logic                      outMisaligned
);

  state_t                    state;
  logic [2:0]                lat_offset;
  logic [2:0]                lat_load_type;
  logic [4:0]                lat_rd;
  logic                      lat_reg_write;
  logic                      lat_mem_or_reg;
  logic [BUS_DATA_WIDTH-1:0] lat_result;

  logic                      mem_op;
  logic [2:0]                align_offset;
  logic [2:0]                align_load_type;
  logic [7:0]                align_byte_en;
  logic [BUS_DATA_WIDTH-1:0] align_wdata;
  logic [BUS_DATA_WIDTH-1:0] align_load_data;
  logic                      align_misaligned;

  assign mem_op = inMemRead | inMemWrite;

  // In BUSY the aligner extracts load data using the latched offset/type;
  // in IDLE it encodes the incoming instruction.
  assign align_offset    = (state == BUSY) ? lat_offset    : inResult[2:0];
  assign align_load_type = (state == BUSY) ? lat_load_type : inLoadType;

  mem_align u_align (
    .offset     (align_offset),
    .is_store   (inMemWrite),
    .load_type  (align_load_type),
    .store_type (inStoreType),
    .store_data (inDataReg2),
    .load_raw   (inMemRdata),
    .byte_en    (align_byte_en),
    .wdata      (align_wdata),
    .load_data  (align_load_data),
    .misaligned (align_misaligned)
  );

  // Stall upstream in the accept cycle and for every BUSY cycle without ack
  always_comb begin
    outStall = 1'b0;
    case (state)
      IDLE:    outStall = inValid & mem_op & ~align_misaligned;
      BUSY:    outStall = ~inMemAck;
      default: outStall = 1'b0;
    endcase
  end

  // Two-state transaction FSM with registered cache and writeback outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state           <= IDLE;
      outMemReq       <= 1'b0;
      outMemWe        <= 1'b0;
      outMemAddr      <= '0;
      outMemWdata     <= '0;
      outMemByteEn    <= '0;
      outValid        <= 1'b0;
      outRegWrite     <= 1'b0;
      outDestRegister <= '0;
      outWriteData    <= '0;
      outMisaligned   <= 1'b0;
      lat_offset      <= '0;
      lat_load_type   <= '0;
      lat_rd          <= '0;
      lat_reg_write   <= 1'b0;
      lat_mem_or_reg  <= 1'b0;
      lat_result      <= '0;
    end else begin
      outValid      <= 1'b0;
      outRegWrite   <= 1'b0;
      outMisaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (inValid) begin
            if (!mem_op) begin
              outValid        <= 1'b1;
              outRegWrite     <= inRegWrite;
              outWriteData    <= inResult;
              outDestRegister <= inDestRegister;
            end else if (align_misaligned) begin
              outValid        <= 1'b1;
              outMisaligned   <= 1'b1;
              outWriteData    <= inResult;
              outDestRegister <= inDestRegister;
            end else begin
              state          <= BUSY;
              outMemReq      <= 1'b1;
              outMemWe       <= inMemWrite;
              outMemAddr     <= {inResult[ADDR_WIDTH-1:3], 3'b000};
              outMemWdata    <= align_wdata;
              outMemByteEn   <= align_byte_en;
              lat_offset     <= inResult[2:0];
              lat_load_type  <= inLoadType;
              lat_rd         <= inDestRegister;
              lat_reg_write  <= inRegWrite & ~inMemWrite;
              lat_mem_or_reg <= inMemOrReg & ~inMemWrite;
              lat_result     <= inResult;
            end
          end
        end
        BUSY: begin
          if (inMemAck) begin
            state           <= IDLE;
            outMemReq       <= 1'b0;
            outValid        <= 1'b1;
            outRegWrite     <= lat_reg_write;
            outDestRegister <= lat_rd;
            outWriteData    <= lat_mem_or_reg ? align_load_data : lat_result;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for the memory-access stage.
module tb_mem_access;
  import mem_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        inValid;
  logic [63:0] inResult;
  logic [63:0] inDataReg2;
  logic        inMemRead;
  logic        inMemWrite;
  logic        inMemOrReg;
  logic        inRegWrite;
  logic [4:0]  inDestRegister;
  logic [2:0]  inLoadType;
  logic [1:0]  inStoreType;
  logic        outMemReq;
  logic        outMemWe;
  logic [63:0] outMemAddr;
  logic [63:0] outMemWdata;
  logic [7:0]  outMemByteEn;
  logic        inMemAck;
  logic [63:0] inMemRdata;
  logic        outStall;
  logic        outValid;
  logic        outRegWrite;
  logic [4:0]  outDestRegister;
  logic [63:0] outWriteData;
  logic        outMisaligned;

  int tests  = 0;
  int failed = 0;

  mem_access dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .inValid         (inValid),
    .inResult        (inResult),
    .inDataReg2      (inDataReg2),
    .inMemRead       (inMemRead),
    .inMemWrite      (inMemWrite),
    .inMemOrReg      (inMemOrReg),
    .inRegWrite      (inRegWrite),
    .inDestRegister  (inDestRegister),
    .inLoadType      (inLoadType),
    .inStoreType     (inStoreType),
    .outMemReq       (outMemReq),
    .outMemWe        (outMemWe),
    .outMemAddr      (outMemAddr),
    .outMemWdata     (outMemWdata),
    .outMemByteEn    (outMemByteEn),
    .inMemAck        (inMemAck),
    .inMemRdata      (inMemRdata),
    .outStall        (outStall),
    .outValid        (outValid),
    .outRegWrite     (outRegWrite),
    .outDestRegister (outDestRegister),
    .outWriteData    (outWriteData),
    .outMisaligned   (outMisaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd_op, input logic wr_op, input logic [63:0] res,
                        input logic [63:0] data, input logic [2:0] lt, input logic [1:0] st,
                        input logic [4:0] rd, input logic rw, input logic mor);
    inValid        = 1'b1;
    inMemRead      = rd_op;
    inMemWrite     = wr_op;
    inResult       = res;
    inDataReg2     = data;
    inLoadType     = lt;
    inStoreType    = st;
    inDestRegister = rd;
    inRegWrite     = rw;
    inMemOrReg     = mor;
  endtask

  task automatic idle_in;
    inValid    = 1'b0;
    inMemRead  = 1'b0;
    inMemWrite = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    idle_in();
    inResult = '0; inDataReg2 = '0; inMemOrReg = 0; inRegWrite = 0;
    inDestRegister = '0; inLoadType = '0; inStoreType = '0;
    inMemAck = 1'b0; inMemRdata = '0;
    tick(); tick();
    check("rst_valid", outValid, 0);
    check("rst_req", outMemReq, 0);
    check("rst_byteen", outMemByteEn, 0);
    check("rst_wdata", outWriteData, 0);
    check("rst_stall", outStall, 0);
    reset_n = 1'b1;
    tick();

    // ALU op: one-cycle latency, no request
    set_op(0, 0, 64'h1234, 0, LT_LB, ST_SB, 5'd5, 1, 0);
    #1 check("alu_stall", outStall, 0);
    tick();
    idle_in();
    check("alu_valid", outValid, 1);
    check("alu_data", outWriteData, 64'h1234);
    check("alu_rd", outDestRegister, 5);
    check("alu_rw", outRegWrite, 1);
    check("alu_noreq", outMemReq, 0);
    tick();
    check("alu_pulse", outValid, 0);
    check("alu_rw_pulse", outRegWrite, 0);

    // lb at 0x1003, ack on third request cycle
    set_op(1, 0, 64'h1003, 0, LT_LB, ST_SB, 5'd7, 1, 1);
    #1 check("lb_accept_stall", outStall, 1);
    tick();
    check("lb_req", outMemReq, 1);
    check("lb_addr", outMemAddr, 64'h1000);
    check("lb_we", outMemWe, 0);
    check("lb_byteen", outMemByteEn, 8'hFF);
    check("lb_stall1", outStall, 1);
    tick();
    check("lb_stall2", outStall, 1);
    check("lb_valid_wait", outValid, 0);
    tick();
    inMemAck = 1'b1;
    inMemRdata = 64'h0000_0000_8000_0000;
    #1 check("lb_ack_stall", outStall, 0);
    tick();
    inMemAck = 1'b0;
    idle_in();
    check("lb_valid", outValid, 1);
    check("lb_data", outWriteData, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_rd", outDestRegister, 7);
    check("lb_rw", outRegWrite, 1);
    check("lb_req_drop", outMemReq, 0);

    // lwu then lw at 0x2004 with ack on the first request cycle
    set_op(1, 0, 64'h2004, 0, LT_LWU, ST_SB, 5'd9, 1, 1);
    tick();
    check("lwu_req", outMemReq, 1);
    check("lwu_addr", outMemAddr, 64'h2000);
    inMemAck = 1'b1;
    inMemRdata = 64'h89AB_CDEF_0000_0000;
    tick();
    inMemAck = 1'b0;
    check("lwu_valid", outValid, 1);
    check("lwu_data", outWriteData, 64'h0000_0000_89AB_CDEF);
    set_op(1, 0, 64'h2004, 0, LT_LW, ST_SB, 5'd10, 1, 1);
    tick();
    check("lw_req", outMemReq, 1);
    check("lw_no_valid", outValid, 0);
    inMemAck = 1'b1;
    tick();
    inMemAck = 1'b0;
    idle_in();
    check("lw_data", outWriteData, 64'hFFFF_FFFF_89AB_CDEF);
    check("lw_rd", outDestRegister, 10);

    // sh at 0x3006
    set_op(0, 1, 64'h3006, 64'hFFFF_FFFF_FFFF_BEEF, LT_LB, ST_SH, 5'd4, 1, 0);
    tick();
    check("sh_byteen", outMemByteEn, 8'hC0);
    check("sh_wdata", outMemWdata, 64'hBEEF_0000_0000_0000);
    check("sh_we", outMemWe, 1);
    check("sh_addr", outMemAddr, 64'h3000);
    tick();
    check("sh_req_hold", outMemReq, 1);
    check("sh_byteen_hold", outMemByteEn, 8'hC0);
    inMemAck = 1'b1;
    tick();
    inMemAck = 1'b0;
    idle_in();
    check("sh_valid", outValid, 1);
    check("sh_rw", outRegWrite, 0);
    check("sh_req_drop", outMemReq, 0);

    // sw at 0x4006: crosses the doubleword
    set_op(0, 1, 64'h4006, 64'h1122_3344, LT_LB, ST_SW, 5'd2, 1, 0);
    #1 check("sw_mis_stall", outStall, 0);
    tick();
    idle_in();
    check("sw_mis_flag", outMisaligned, 1);
    check("sw_mis_valid", outValid, 1);
    check("sw_mis_rw", outRegWrite, 0);
    check("sw_mis_noreq", outMemReq, 0);
    tick();
    check("sw_mis_pulse", outMisaligned, 0);
    check("sw_mis_vpulse", outValid, 0);

    // Read and write both set: treated as sd
    set_op(1, 1, 64'h4008, 64'h0123_4567_89AB_CDEF, LT_LD, ST_SD, 5'd6, 1, 1);
    tick();
    check("sd_we", outMemWe, 1);
    check("sd_byteen", outMemByteEn, 8'hFF);
    check("sd_wdata", outMemWdata, 64'h0123_4567_89AB_CDEF);
    inMemAck = 1'b1;
    tick();
    inMemAck = 1'b0;
    idle_in();
    check("sd_rw", outRegWrite, 0);

    // Ack while idle is ignored
    inMemAck = 1'b1;
    tick();
    inMemAck = 1'b0;
    check("idle_ack_valid", outValid, 0);
    check("idle_ack_req", outMemReq, 0);

    // Reset while BUSY, then a late ack
    set_op(1, 0, 64'h5010, 0, LT_LD, ST_SB, 5'd11, 1, 1);
    tick();
    check("rb_req", outMemReq, 1);
    reset_n = 1'b0;
    idle_in();
    #1;
    check("rb_req0", outMemReq, 0);
    check("rb_addr0", outMemAddr, 0);
    check("rb_byteen0", outMemByteEn, 0);
    check("rb_wdata0", outMemWdata, 0);
    check("rb_data0", outWriteData, 0);
    check("rb_rd0", outDestRegister, 0);
    check("rb_stall0", outStall, 0);
    tick();
    reset_n = 1'b1;
    tick();
    inMemAck = 1'b1;
    inMemRdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    inMemAck = 1'b0;
    check("rb_late_ack_valid", outValid, 0);
    check("rb_late_ack_data", outWriteData, 0);
    set_op(0, 0, 64'h55, 0, LT_LB, ST_SB, 5'd3, 1, 0);
    tick();
    idle_in();
    check("rb_alu_valid", outValid, 1);
    check("rb_alu_data", outWriteData, 64'h55);
    check("rb_alu_rd", outDestRegister, 3);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
Memory-access stage that consumes the execute stage's registered outputs: ALU result, store data, memory/writeback controls, load and store type. It turns loads and stores into a request/acknowledge transaction on the 64-bit data-cache port. It sign- or zero-extends load data and forwards a writeback packet to the WB stage. It stalls the upstream pipeline while a cache transaction is outstanding.

Parameters:
BUS_DATA_WIDTH, 64, datapath and cache data width in bits; only 64 is supported.
ADDR_WIDTH, 64, width of the cache address.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
inValid  in  1  execute output holds a valid instruction
inResult  in  BUS_DATA_WIDTH  ALU result; used as the effective address for loads and stores
inDataReg2  in  BUS_DATA_WIDTH  store data (rs2)
inMemRead  in  1  instruction is a load
inMemWrite  in  1  instruction is a store
inMemOrReg  in  1  1 selects load data for writeback, 0 selects inResult
inRegWrite  in  1  instruction writes rd
inDestRegister  in  5  rd
inLoadType  in  3  000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
inStoreType  in  2  00 sb, 01 sh, 10 sw, 11 sd
outMemReq  out  1  cache request, held until acknowledged
outMemWe  out  1  1 = store
outMemAddr  out  ADDR_WIDTH  doubleword-aligned address (low 3 bits forced to 0)
outMemWdata  out  BUS_DATA_WIDTH  store data shifted into its byte lane
outMemByteEn  out  8  byte-lane enables for stores; all ones for loads
inMemAck  in  1  cache completes the request this cycle
inMemRdata  in  BUS_DATA_WIDTH  aligned doubleword; valid only with inMemAck
outStall  out  1  upstream must hold its outputs this cycle
outValid  out  1  WB packet valid (one-cycle pulse per instruction)
outRegWrite  out  1  WB register-write enable
outDestRegister  out  5  WB rd
outWriteData  out  BUS_DATA_WIDTH  WB data
outMisaligned  out  1  one-cycle pulse: access crossed an 8-byte boundary

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE; every output 0, outMemByteEn included. An outstanding request is dropped with no completion; an inMemAck arriving after reset is ignored.
- FSM has two states, IDLE and BUSY.
- IDLE, inValid with neither inMemRead nor inMemWrite:
  - next cycle outValid=1, outRegWrite=inRegWrite, outWriteData=inResult, outDestRegister=inDestRegister.
  - latency is 1 cycle; outStall=0.
- IDLE, inValid with a memory op, aligned (offset = inResult[2:0]; size 1/2/4/8 bytes; offset+size<=8):
  - latch address, lane, type, rd, regWrite, memOrReg.
  - next cycle: outMemReq=1 and state BUSY. outStall=1 combinationally in the accept cycle.
- IDLE, misaligned access: no request; next cycle outMisaligned=1, outValid=1, outRegWrite=0.
- BUSY:
  - outMemReq, outMemAddr, outMemWe, outMemWdata and outMemByteEn stay stable until inMemAck.
  - outStall = !inMemAck.
  - on inMemAck: next cycle outValid=1, outMemReq=0, state IDLE.
  - new inputs are ignored in BUSY; upstream holds them because of outStall.
  - the earliest ack is the first cycle outMemReq=1, giving minimum load latency of 2 cycles (accept to outValid).
- Store encoding:
  - outMemWdata = inDataReg2 shifted left by 8*offset.
  - outMemByteEn = size mask shifted left by offset: sb 0x01, sh 0x03, sw 0x0F, sd 0xFF.
  - store completion: outValid=1, outRegWrite=0.
- Load data:
  - lane = inMemRdata >> 8*offset.
  - lb/lh/lw sign-extend from bit 7/15/31; lbu/lhu/lwu zero-extend; ld passes through.
  - outWriteData = inMemOrReg ? extended : latched result.
  - undefined inLoadType values (111) behave as ld.
- inMemRead and inMemWrite both 1: treated as a store.
- inMemAck while IDLE: ignored.
- outValid, outMisaligned and outRegWrite are one-cycle pulses. outWriteData and outDestRegister hold their value until the next outValid.

Decomposition:
- Package mem_pkg: load-type and store-type localparams, the IDLE/BUSY state enum, size-from-type function.
- Sub-module mem_align (combinational): takes offset, type and data; produces byte enables, shifted store data, extended load data, and the misaligned flag.
- The FSM and registers live in mem_access.

Test Plan:
- ALU op, inResult=0x1234, rd=5, regWrite=1 -> next cycle outValid=1, outWriteData=0x1234, outDestRegister=5, no outMemReq.
- lb at addr 0x1003, ack after 3 cycles with rdata=0x00000000_80000000 -> outMemAddr=0x1000; outWriteData=0xFFFFFFFF_FFFFFF80; outStall high until the ack cycle.
- lwu at 0x2004, rdata=0x89ABCDEF_00000000 -> outWriteData=0x00000000_89ABCDEF; lw at the same address -> 0xFFFFFFFF_89ABCDEF.
- sh at 0x3006, data=0xBEEF -> outMemByteEn=0xC0, outMemWdata=0xBEEF0000_00000000, outMemWe=1; after ack, outValid=1 and outRegWrite=0.
- sw at 0x4006 -> no outMemReq, outMisaligned=1 for one cycle, outRegWrite=0.
- Assert reset_n=0 while BUSY, then ack 2 cycles after reset_n rises -> all outputs 0, the ack is ignored, and the next ALU op completes normally.
